// File: rtl/perceptron_mac_sequencer_pkg.sv
// Shared types and activation rule for the perceptron datapath and its MAC sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: default sizes, Act_Func encoding, FSM state enum, af_apply().
package perceptron_mac_sequencer_pkg;

  localparam int P_N_INPUTS = 3;
  localparam int P_DATA_W   = 8;
  // af_apply works on a wide signed value so any accumulator width fits;
  // callers sign-extend in and truncate back out.
  localparam int AF_W       = 64;

  typedef enum logic [1:0] {
    ReLU   = 2'd0,
    STEP   = 2'd1,
    LINEAR = 2'd2
  } Act_Func;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Unknown encodings (2'd3) fall through to the identity.
  function automatic logic signed [AF_W-1:0] af_apply(
    input logic signed [AF_W-1:0] acc,
    input Act_Func                sel
  );
    logic signed [AF_W-1:0] res;
    logic                   neg;
    logic                   pos;
    neg = acc[AF_W-1];
    pos = !acc[AF_W-1] && (acc != '0);
    res = acc;
    case (sel)
      ReLU:    res = neg ? '0 : acc;
      STEP:    res = pos ? AF_W'(1) : '0;
      default: res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/perceptron_mac_sequencer_if.sv
// Operand/result bundle between layer scheduler, MAC sequencer and result collector.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// master = scheduler/collector side, slave = sequencer side; soft_clr and busy ride along.
interface perceptron_mac_sequencer_if
  import perceptron_mac_sequencer_pkg::*;
#(
  parameter int N_INPUTS = P_N_INPUTS,
  parameter int DATA_W   = P_DATA_W
);
  localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS+1);

  logic                         soft_clr;
  logic                         in_valid;
  logic                         in_ready;
  logic [N_INPUTS*DATA_W-1:0]   weights_in;
  logic [N_INPUTS*DATA_W-1:0]   values_in;
  logic signed [DATA_W-1:0]     bias_in;
  Act_Func                      activation;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_W-1:0]      prediction;
  logic                         pred_bit;
  logic                         busy;

  modport master (
    output soft_clr, in_valid, weights_in, values_in, bias_in, activation, out_ready,
    input  in_ready, out_valid, prediction, pred_bit, busy
  );

  modport slave (
    input  soft_clr, in_valid, weights_in, values_in, bias_in, activation, out_ready,
    output in_ready, out_valid, prediction, pred_bit, busy
  );

endinterface

// File: rtl/perceptron_mac_sequencer_mac_unit.sv
// One signed multiply-accumulate step: acc_o = acc_i + w_i*v_i.
// Latency: combinational.
// Backpressure: none.
// Ports: w_i/v_i signed operands, acc_i running sum, acc_o updated sum.
module perceptron_mac_sequencer_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] v_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod;

  // Full-width signed product; the accumulator is wide enough that nothing wraps.
  assign prod  = (2*DATA_W)'(w_i) * (2*DATA_W)'(v_i);
  assign acc_o = acc_i + ACC_W'(prod);

endmodule

// File: rtl/perceptron_mac_sequencer.sv
// Time-multiplexes one MAC over N_INPUTS weight/value pairs, adds bias, applies activation.
// Latency: out_valid rises N_INPUTS+1 cycles after accept; initiation interval N_INPUTS+2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; soft_clr aborts.
// Ports: clk, rst_n (async active-low), io (slave modport: operands in, result out, busy).
module perceptron_mac_sequencer
  import perceptron_mac_sequencer_pkg::*;
#(
  parameter int N_INPUTS = P_N_INPUTS,
  parameter int DATA_W   = P_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  perceptron_mac_sequencer_if.slave  io
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS+1);
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS-1);

  seq_state_t               state_q, state_d;
  logic                     accept, mac_step, act_load;

  logic signed [DATA_W-1:0] w_q [N_INPUTS];
  logic signed [DATA_W-1:0] v_q [N_INPUTS];
  Act_Func                  act_q;

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  mac_acc;
  logic signed [ACC_W-1:0]  pred_q, pred_d;
  logic                     pred_bit_q, pred_bit_d;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mac_step = 1'b0;
    act_load = 1'b0;
    // soft_clr overrides everything, including an IDLE accept and a DONE handshake.
    if (io.soft_clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          accept  = 1'b1;
          state_d = MAC;
        end
        MAC: begin
          mac_step = 1'b1;
          if (idx_q == IDX_LAST) state_d = ACT;
        end
        ACT: begin
          act_load = 1'b1;
          state_d  = DONE;
        end
        DONE: if (io.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- Datapath ----------------
  perceptron_mac_sequencer_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .w_i   (w_q[idx_q]),
    .v_i   (v_q[idx_q]),
    .acc_i (acc_q),
    .acc_o (mac_acc)
  );

  always_comb begin
    acc_d      = acc_q;
    idx_d      = idx_q;
    pred_d     = pred_q;
    pred_bit_d = pred_bit_q;
    if (accept) begin
      // Bias seeds the accumulator so no extra add cycle is needed.
      acc_d = ACC_W'(io.bias_in);
      idx_d = '0;
    end else if (mac_step) begin
      acc_d = mac_acc;
      idx_d = idx_q + IDX_W'(1);
    end else if (act_load) begin
      pred_d     = ACC_W'(af_apply(AF_W'(acc_q), act_q));
      pred_bit_d = !acc_q[ACC_W-1] && (acc_q != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      idx_q      <= '0;
      pred_q     <= '0;
      pred_bit_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      pred_q     <= pred_d;
      pred_bit_q <= pred_bit_d;
    end
  end

  // Private operand copy: upstream may change its bus freely after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        w_q[i] <= '0;
        v_q[i] <= '0;
      end
      act_q <= ReLU;
    end else if (accept) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        w_q[i] <= io.weights_in[i*DATA_W +: DATA_W];
        v_q[i] <= io.values_in[i*DATA_W +: DATA_W];
      end
      act_q <= io.activation;
    end
  end

  assign io.in_ready   = (state_q == IDLE);
  assign io.out_valid  = (state_q == DONE);
  assign io.busy       = (state_q != IDLE);
  assign io.prediction = pred_q;
  assign io.pred_bit   = pred_bit_q;

endmodule

// File: tb/tb_perceptron_mac_sequencer.sv
// Scoreboard bench for perceptron_mac_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on every completed output handshake.
module tb_perceptron_mac_sequencer;
  import perceptron_mac_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  perceptron_mac_sequencer_if bus ();

  perceptron_mac_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int n_total  = 0;
  int n_pass   = 0;
  int hs_count = 0;
  int exp_pred_q [$];
  bit exp_bit_q  [$];

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- Monitor ----------------
  initial begin
    int ep;
    bit eb;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.soft_clr === 1'b0) begin
        hs_count++;
        if (exp_pred_q.size() == 0) begin
          chk("unexpected_result", 1'b0, bus.prediction, 0);
        end else begin
          ep = exp_pred_q.pop_front();
          eb = exp_bit_q.pop_front();
          chk("prediction", bus.prediction == ep, bus.prediction, ep);
          chk("pred_bit", bus.pred_bit === eb, bus.pred_bit, eb);
        end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) chk(name, 1'b0, bus.in_ready, 1);
  endtask

  task automatic send(input int w0, input int w1, input int w2,
                      input int v0, input int v1, input int v2,
                      input int b, input Act_Func af,
                      input bit push, input int ep, input bit eb);
    wait_ready("send_wait_in_ready");
    if (push) begin
      exp_pred_q.push_back(ep);
      exp_bit_q.push_back(eb);
    end
    bus.weights_in = {8'(w2), 8'(w1), 8'(w0)};
    bus.values_in  = {8'(v2), 8'(v1), 8'(v0)};
    bus.bias_in    = 8'(b);
    bus.activation = af;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    // Scramble the bus: the sequencer must work from its latched copy.
    bus.weights_in = '1;
    bus.values_in  = '1;
    bus.bias_in    = '1;
    bus.activation = STEP;
  endtask

  // Cycles from accept until out_valid; also reports whether in_ready stayed low
  // and busy stayed high the whole way.
  task automatic wait_valid(input string name, output int cycles, output bit rdy_low);
    cycles  = 0;
    rdy_low = 1'b1;
    while (bus.out_valid !== 1'b1 && cycles < 20) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) rdy_low = 1'b0;
      tick();
      cycles++;
    end
    if (bus.out_valid !== 1'b1) chk(name, 1'b0, cycles, 20);
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    int cyc;
    bit ok;
    int hs0;

    rst_n          = 1'b0;
    bus.soft_clr   = 1'b0;
    bus.in_valid   = 1'b0;
    bus.weights_in = '0;
    bus.values_in  = '0;
    bus.bias_in    = '0;
    bus.activation = ReLU;
    bus.out_ready  = 1'b1;
    #12 rst_n = 1'b1;
    tick();

    chk("rst_in_ready",   bus.in_ready === 1'b1,  bus.in_ready,   1);
    chk("rst_out_valid",  bus.out_valid === 1'b0, bus.out_valid,  0);
    chk("rst_busy",       bus.busy === 1'b0,      bus.busy,       0);
    chk("rst_prediction", bus.prediction === '0,  bus.prediction, 0);
    chk("rst_pred_bit",   bus.pred_bit === 1'b0,  bus.pred_bit,   0);

    // 1: 1*1+1*2+1*3+1 = 7
    send(1, 1, 1, 1, 2, 3, 1, ReLU, 1'b1, 7, 1'b1);
    wait_valid("t1_wait_valid", cyc, ok);
    chk("t1_latency", cyc == 4, cyc, 4);
    chk("t1_in_ready_low_busy", ok, ok, 1);

    // 2: -6+1+0+0 = -5 under each activation
    send(-2, 1, 0, 3, 1, 5, 0, ReLU,   1'b1,  0, 1'b0);
    send(-2, 1, 0, 3, 1, 5, 0, LINEAR, 1'b1, -5, 1'b0);
    send(-2, 1, 0, 3, 1, 5, 0, STEP,   1'b1,  0, 1'b0);
    send(-2, 1, 0, 3, 1, 5, 0, Act_Func'(2'd3), 1'b1, -5, 1'b0);
    send(1, 1, 1, 1, 2, 3, 1, STEP,    1'b1,  1, 1'b1);

    // 3: extremes, 3*16384+127 and 3*(-16256)-128
    send(-128, -128, -128, -128, -128, -128,  127, LINEAR, 1'b1,  49279, 1'b1);
    send(-128, -128, -128,  127,  127,  127, -128, LINEAR, 1'b1, -48896, 1'b0);
    send(-128, -128, -128,  127,  127,  127, -128, ReLU,   1'b1,      0, 1'b0);
    send(-128, -128, -128, -128, -128, -128,  127, ReLU,   1'b1,  49279, 1'b1);

    // 4: backpressure
    wait_ready("t4_pre_ready");
    bus.out_ready = 1'b0;
    send(1, 1, 1, 1, 2, 3, 1, LINEAR, 1'b1, 7, 1'b1);
    wait_valid("t4_wait_valid", cyc, ok);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.prediction != 7 || bus.pred_bit !== 1'b1 || bus.in_ready !== 1'b0)
        ok = 1'b0;
      if (i == 3) begin
        bus.weights_in = {8'd9, 8'd9, 8'd9};
        bus.values_in  = {8'd9, 8'd9, 8'd9};
        bus.in_valid   = 1'b1;
      end
      if (i == 4) bus.in_valid = 1'b0;
      tick();
    end
    chk("t4_hold_stable", ok, ok, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("t4_idle_after_ready", bus.in_ready === 1'b1 && bus.out_valid === 1'b0, bus.in_ready, 1);
    send(1, 1, 1, 1, 2, 3, 1, STEP, 1'b1, 1, 1'b1);

    // 5: async reset mid-MAC (idx=1)
    send(1, 1, 1, 1, 2, 3, 1, ReLU, 1'b0, 0, 1'b0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid",  bus.out_valid === 1'b0, bus.out_valid,  0);
    chk("t5_rst_busy",       bus.busy === 1'b0,      bus.busy,       0);
    chk("t5_rst_in_ready",   bus.in_ready === 1'b1,  bus.in_ready,   1);
    chk("t5_rst_prediction", bus.prediction === '0,  bus.prediction, 0);
    chk("t5_rst_pred_bit",   bus.pred_bit === 1'b0,  bus.pred_bit,   0);
    #4 rst_n = 1'b1;
    tick();
    send(1, 1, 1, 1, 2, 3, 1, ReLU, 1'b1, 7, 1'b1);

    // 6a: soft_clr during MAC
    send(1, 1, 1, 1, 2, 3, 1, LINEAR, 1'b0, 0, 1'b0);
    bus.soft_clr = 1'b1;
    tick();
    bus.soft_clr = 1'b0;
    chk("t6_idle_after_clr", bus.in_ready === 1'b1 && bus.busy === 1'b0, bus.busy, 0);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("t6_no_out_valid", ok, ok, 1);

    // 6b: soft_clr with in_valid in IDLE blocks the accept
    bus.weights_in = {8'd1, 8'd1, 8'd1};
    bus.values_in  = {8'd1, 8'd1, 8'd1};
    bus.in_valid   = 1'b1;
    bus.soft_clr   = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus.soft_clr   = 1'b0;
    chk("t6_clr_blocks_accept", bus.busy === 1'b0, bus.busy, 0);

    // 6c: soft_clr in DONE with out_ready high drops the result
    bus.out_ready = 1'b0;
    send(1, 1, 1, 1, 2, 3, 1, LINEAR, 1'b0, 0, 1'b0);
    wait_valid("t6_wait_valid", cyc, ok);
    hs0 = hs_count;
    bus.soft_clr  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.soft_clr  = 1'b0;
    chk("t6_done_clr_idle", bus.out_valid === 1'b0 && bus.in_ready === 1'b1, bus.out_valid, 0);
    chk("t6_no_handshake", hs_count == hs0, hs_count, hs0);

    // Recovery: 10-18-28-1 = -37
    send(2, -3, 4, 5, 6, -7, -1, LINEAR, 1'b1, -37, 1'b0);

    cyc = 0;
    while ((exp_pred_q.size() != 0 || bus.in_ready !== 1'b1) && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("drain_queue_empty", exp_pred_q.size() == 0, exp_pred_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
